// File: rtl/mcore_mem_arbiter_if.sv
// Bundle of the requester-side and memory-side buses around mcore_mem_arbiter.
// The master modport is the arbiter's view. The slave modport is the view of the
// environment, which holds both the requesters and the downstream memory port.
interface mcore_mem_arbiter_if #(
  parameter int NUM_REQ    = 3,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic [NUM_REQ-1:0]              s_req;
  logic [NUM_REQ*ADDR_WIDTH-1:0]   s_addr;
  logic [NUM_REQ-1:0]              s_we;
  logic [NUM_REQ*DATA_WIDTH-1:0]   s_wdata;
  logic [NUM_REQ*DATA_WIDTH/8-1:0] s_be;
  logic [NUM_REQ-1:0]              s_gnt;
  logic [NUM_REQ-1:0]              s_rsp_valid;
  logic [DATA_WIDTH-1:0]           s_rsp_rdata;
  logic                            s_rsp_error;

  logic                            mem_req;
  logic [ADDR_WIDTH-1:0]           mem_addr;
  logic                            mem_we;
  logic [DATA_WIDTH-1:0]           mem_wdata;
  logic [DATA_WIDTH/8-1:0]         mem_be;
  logic                            mem_gnt;
  logic                            mem_rsp_valid;
  logic [DATA_WIDTH-1:0]           mem_rsp_rdata;
  logic                            mem_rsp_error;

  modport master (
    input  s_req, s_addr, s_we, s_wdata, s_be,
    output s_gnt, s_rsp_valid, s_rsp_rdata, s_rsp_error,
    output mem_req, mem_addr, mem_we, mem_wdata, mem_be,
    input  mem_gnt, mem_rsp_valid, mem_rsp_rdata, mem_rsp_error
  );

  modport slave (
    output s_req, s_addr, s_we, s_wdata, s_be,
    input  s_gnt, s_rsp_valid, s_rsp_rdata, s_rsp_error,
    input  mem_req, mem_addr, mem_we, mem_wdata, mem_be,
    output mem_gnt, mem_rsp_valid, mem_rsp_rdata, mem_rsp_error
  );
endinterface

// File: rtl/mcore_mem_arbiter.sv
// mcore_mem_arbiter: shares one external memory port among NUM_REQ requesters.
// Arbitration is round-robin by default. Define MCORE_ARB_FIXED_PRIO_EN for
// fixed priority, where the lowest index wins and rr_ptr does not exist.
// Responses come back in order. An ID FIFO records the owner of every
// accepted transaction so that each response strobe reaches the right requester.
module mcore_mem_arbiter #(
  parameter int NUM_REQ         = 3,
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                 aclk,
  input  logic                 rst,
  mcore_mem_arbiter_if.master  bus,
  output logic                 busy,
  output logic                 err_unexp_rsp
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;
  localparam int BE_W  = DATA_WIDTH / 8;
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  typedef enum logic {ST_ARB, ST_WAIT} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] sel_q, sel_d;
  logic [IDX_W-1:0] arb_winner;
  logic             arb_found;
  logic [IDX_W-1:0] cur;
  logic             req_out;
  logic             handshake;
  logic             push, pop, room;

  logic [IDX_W-1:0] id_mem [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic [IDX_W-1:0] head_id;

`ifdef MCORE_ARB_FIXED_PRIO_EN
  // Fixed priority: the lowest-index active requester wins.
  always_comb begin
    arb_found  = 1'b0;
    arb_winner = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.s_req[i]) begin
        arb_found  = 1'b1;
        arb_winner = IDX_W'(i);
      end
    end
  end
`else
  localparam logic [IDX_W:0] NUM_REQ_W = (IDX_W + 1)'(NUM_REQ);

  logic [IDX_W-1:0]     rr_ptr;
  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic [IDX_W:0]       rr_sum;

  // Round-robin: rotate the requests so that rr_ptr sits at bit 0, find the
  // first set bit, then map that offset back to an absolute index.
  always_comb begin
    req_dbl   = {bus.s_req, bus.s_req} >> rr_ptr;
    req_rot   = req_dbl[NUM_REQ-1:0];
    arb_found = 1'b0;
    rr_sum    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        arb_found = 1'b1;
        rr_sum    = (IDX_W + 1)'(i);
      end
    end
    rr_sum = rr_sum + {1'b0, rr_ptr};
    if (rr_sum >= NUM_REQ_W) begin
      rr_sum = rr_sum - NUM_REQ_W;
    end
    arb_winner = rr_sum[IDX_W-1:0];
  end

  // After each accepted handshake, priority moves to the port just past the winner.
  always_ff @(posedge aclk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (handshake) begin
      rr_ptr <= (cur == LAST_IDX) ? '0 : cur + IDX_W'(1);
    end
  end
`endif

  // A response pops the FIFO only when it holds an entry. Room to issue is
  // judged on the post-pop occupancy, so a pop frees a slot in the same cycle.
  always_comb begin
    pop       = bus.mem_rsp_valid && (count != '0);
    room      = (count - CNT_W'(pop)) != MAX_CNT;
    handshake = req_out && bus.mem_gnt;
    push      = handshake;
  end

  // ARB presents the current winner. WAIT locks onto the stalled selection
  // until the downstream grants it.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    req_out = 1'b0;
    cur     = arb_winner;
    case (state_q)
      ST_ARB: begin
        if (arb_found && room) begin
          req_out = 1'b1;
          if (!bus.mem_gnt) begin
            state_d = ST_WAIT;
            sel_d   = arb_winner;
          end
        end
      end
      ST_WAIT: begin
        cur     = sel_q;
        req_out = 1'b1;
        if (bus.mem_gnt) begin
          state_d = ST_ARB;
        end
      end
      default: state_d = ST_ARB;
    endcase
  end

  // State register and the locked selection.
  always_ff @(posedge aclk) begin
    if (rst) begin
      state_q <= ST_ARB;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  // The downstream payload comes from the selected requester and is zero when idle.
  always_comb begin
    bus.mem_req   = req_out;
    bus.mem_addr  = '0;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = '0;
    bus.mem_be    = '0;
    if (req_out) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (cur == IDX_W'(i)) begin
          bus.mem_addr  = bus.s_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
          bus.mem_we    = bus.s_we[i];
          bus.mem_wdata = bus.s_wdata[i*DATA_WIDTH +: DATA_WIDTH];
          bus.mem_be    = bus.s_be[i*BE_W +: BE_W];
        end
      end
    end
  end

  // The grant goes to the requester being served and the response goes to the FIFO head.
  always_comb begin
    bus.s_gnt       = '0;
    bus.s_rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (handshake && (cur == IDX_W'(i))) begin
        bus.s_gnt[i] = 1'b1;
      end
      if (pop && (head_id == IDX_W'(i))) begin
        bus.s_rsp_valid[i] = 1'b1;
      end
    end
    bus.s_rsp_rdata = bus.mem_rsp_rdata;
    bus.s_rsp_error = bus.mem_rsp_error;
  end

  // ID storage. It needs no reset because the pointers and count define which entries are valid.
  always_ff @(posedge aclk) begin
    if (push) begin
      id_mem[wr_ptr] <= cur;
    end
  end

  assign head_id = id_mem[rd_ptr];

  // FIFO pointers and occupancy. A simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge aclk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky flag for a response that arrives with nothing outstanding.
  always_ff @(posedge aclk) begin
    if (rst) begin
      err_unexp_rsp <= 1'b0;
    end else if (bus.mem_rsp_valid && (count == '0)) begin
      err_unexp_rsp <= 1'b1;
    end
  end

  assign busy = (count != '0) || (state_q == ST_WAIT);

endmodule
